// File: rtl/decoder24_strobe.sv
`timescale 1ns/1ps
// 2-to-4 one-hot strobe generator: each accepted index becomes a registered strobe held for
// HOLD_CYCLES cycles, optionally followed by GAP_CYCLES forced idle cycles.
module decoder24_strobe #(
    parameter int HOLD_CYCLES = 1,
    parameter int GAP_CYCLES  = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] dataIn,
    input  logic       validIn,
    output logic       readyOut,
    input  logic       enable,
    output logic [3:0] dataOut,
    output logic       busy,
    output logic       doneOut
);

    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255 || GAP_CYCLES < 0 || GAP_CYCLES > 255) begin : g_bad_param
        $error("decoder24_strobe: HOLD_CYCLES must be 1..255 and GAP_CYCLES 0..255");
    end

    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] GAP_LOAD  = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;
    localparam bit         HAS_GAP   = (GAP_CYCLES > 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] data_q, data_d;
    logic       live_q;
    logic       ready_raw;
    logic       last_hold;
    logic       accept;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        data_d    = 4'b0000;
        ready_raw = 1'b0;
        last_hold = (state_q == HOLD) && (cnt_q == 8'd0);

        case (state_q)
            IDLE:    ready_raw = enable;
            HOLD:    ready_raw = last_hold && !HAS_GAP && enable;
            default: ready_raw = 1'b0;
        endcase

        // readyOut stays low until the first edge after reset has been released
        accept = validIn && ready_raw && live_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LOAD;
                    idx_d   = dataIn;
                end
            end
            HOLD: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else if (HAS_GAP) begin
                    state_d = GAP;
                    cnt_d   = GAP_LOAD;
                end else if (accept) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LOAD;
                    idx_d   = dataIn;
                end else begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end
            end
            GAP: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase

        if (state_d == HOLD) begin
            data_d = 4'b0001 << idx_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            idx_q   <= 2'd0;
            data_q  <= 4'b0000;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            live_q  <= 1'b1;
        end
    end

    assign readyOut = ready_raw && live_q;
    assign dataOut  = data_q;
    assign busy     = (state_q != IDLE);
    assign doneOut  = last_hold;

endmodule

// File: doc/decoder24_strobe.md
DECODER24_STROBE -- requirements
Module: decoder24_strobe

Interface
REQ-001 The block SHALL have parameter HOLD_CYCLES, default 1, giving the number of cycles each one-hot strobe is held; legal range 1..255.
REQ-002 The block SHALL have parameter GAP_CYCLES, default 0, giving the number of idle cycles forced after each strobe; legal range 0..255.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port dataIn, input, 2 bits: binary index to decode.
REQ-006 The block SHALL have port validIn, input, 1 bit: dataIn is valid.
REQ-007 The block SHALL have port readyOut, output, 1 bit: the block can accept dataIn this cycle.
REQ-008 The block SHALL have port enable, input, 1 bit: gates acceptance of new requests.
REQ-009 The block SHALL have port dataOut, output, 4 bits: one-hot strobe, registered.
REQ-010 The block SHALL have port busy, output, 1 bit: the FSM is not in IDLE.
REQ-011 The block SHALL have port doneOut, output, 1 bit: single-cycle pulse on the last cycle of each strobe.

Function
REQ-012 The block SHALL implement a three-state FSM with states IDLE, HOLD and GAP.
REQ-013 The block SHALL accept a request on a rising edge only when validIn and readyOut are both 1.
REQ-014 readyOut SHALL equal enable in IDLE, 0 in GAP, and 0 in HOLD, except in the last HOLD cycle when GAP_CYCLES is 0, where it SHALL equal enable.
REQ-015 On an accept, the block SHALL enter HOLD and, from the next cycle, drive dataOut with bit dataIn set and all other bits 0, for exactly HOLD_CYCLES cycles.
REQ-016 The decode SHALL be: 0 -> 4'b0001, 1 -> 4'b0010, 2 -> 4'b0100, 3 -> 4'b1000; the index SHALL be captured at accept and held stable even if dataIn changes.
REQ-017 doneOut SHALL be 1 only in the last HOLD cycle of each strobe.
REQ-018 At the end of HOLD with GAP_CYCLES > 0, the block SHALL enter GAP for exactly GAP_CYCLES cycles with dataOut = 0, then return to IDLE.
REQ-019 At the end of HOLD with GAP_CYCLES = 0, the block SHALL return to IDLE with dataOut = 0, unless a request is accepted in that last HOLD cycle.
REQ-020 A request accepted in the last HOLD cycle SHALL start a new HOLD with no zero cycle between strobes: back-to-back, same or different index.
REQ-021 Timing SHALL use a single 8-bit down-counter, loaded with HOLD_CYCLES-1 on entry to HOLD and GAP_CYCLES-1 on entry to GAP; a state ends when the counter reads 0.
REQ-022 Deasserting enable SHALL NOT abort a strobe or gap already in progress; it only blocks new accepts.
REQ-023 In IDLE, dataOut SHALL be 0 and busy SHALL be 0; in HOLD and GAP, busy SHALL be 1.
REQ-024 HOLD_CYCLES = 0 or either parameter > 255 SHALL be rejected at elaboration.

Reset
REQ-025 While rst = 1, the block SHALL immediately, without waiting for clk, force state to IDLE, counter to 0, captured index to 0, and dataOut = 0, busy = 0, doneOut = 0.
REQ-026 While rst = 1, readyOut SHALL be 0, and it SHALL follow REQ-014 from the first rising edge after rst falls.
REQ-027 Asserting rst mid-HOLD or mid-GAP SHALL abandon the strobe with no doneOut pulse.

Verification
REQ-028 Defaults, enable = 1, dataIn = 2 with validIn held for 1 cycle -> dataOut = 4'b0100 for exactly 1 cycle starting the cycle after accept, doneOut = 1 in that cycle, then dataOut = 0.
REQ-029 HOLD_CYCLES = 3, GAP_CYCLES = 2, continuous validIn cycling dataIn 0,1,3 -> each strobe 3 cycles, 2 zero cycles between strobes, readyOut = 0 throughout HOLD and GAP.
REQ-030 HOLD_CYCLES = 2, GAP_CYCLES = 0, continuous validIn with dataIn 3 then 0 -> dataOut 1000, 1000, 0001, 0001 with no gap, and doneOut = 1 on the 2nd and 4th cycles.
REQ-031 HOLD_CYCLES = 4, enable dropped 1 cycle after accept -> the strobe completes all 4 cycles, and no further accept occurs while enable = 0 despite validIn = 1.
REQ-032 HOLD_CYCLES = 5, rst pulsed asynchronously (between clk edges) in the 3rd HOLD cycle -> dataOut = 0 and busy = 0 before the next edge, with no doneOut pulse.
REQ-033 dataIn changed every cycle during a 4-cycle HOLD -> dataOut stays at the captured one-hot value for all 4 cycles.
